steering_ramp_ctrl: RTL and testbench



---
 rtl/steering_pkg.sv | 25 ++
 rtl/steering_tick_gen.sv | 37 +++
 rtl/steering_ramp_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_steering_ramp_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/steering_pkg.sv
// Shared register map, ID, bit positions and FSM encoding for the steering slew-rate controller.
package steering_pkg;

  localparam logic [2:0] AddrId      = 3'd0;
  localparam logic [2:0] AddrCtrl    = 3'd1;
  localparam logic [2:0] AddrTarget  = 3'd2;
  localparam logic [2:0] AddrStep    = 3'd3;
  localparam logic [2:0] AddrLimits  = 3'd4;
  localparam logic [2:0] AddrStatus  = 3'd5;
  localparam logic [2:0] AddrCurrent = 3'd6;

  localparam logic [31:0] SteeringId = 32'hEA680013;

  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlIrqEnBit = 1;
  localparam int unsigned CtrlWdEnBit  = 2;

  localparam int unsigned StatBusyBit   = 0;
  localparam int unsigned StatDoneBit   = 1;
  localparam int unsigned StatWdTripBit = 2;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRamp = 1'b1;

endpackage

// File: rtl/steering_tick_gen.sv
// Update-tick prescaler: counts 0..TICK_DIV-1 and pulses tick_o for one cycle at the top.
module steering_tick_gen #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'((TICK_DIV > 0) ? TICK_DIV - 1 : 0);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tick_o = !clr_i && (cnt_q == CntMax);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/steering_ramp_ctrl.sv
// Avalon-MM slew-rate controller feeding the steering PWM driver angle input.
// Optional watchdog re-centring is built when STEERING_RAMP_WATCHDOG_EN is defined.
module steering_ramp_ctrl
  import steering_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned MIN_DEF  = 100,
  parameter int unsigned MAX_DEF  = 200,
  parameter int unsigned CENTER   = 150,
  parameter int unsigned WD_TICKS = 25
) (
  input  logic             csi_MCLK_clk,
  input  logic             rsi_MRST_reset,
  input  logic [31:0]      avs_ctrl_writedata,
  output logic [31:0]      avs_ctrl_readdata,
  input  logic [3:0]       avs_ctrl_byteenable,
  input  logic [2:0]       avs_ctrl_address,
  input  logic             avs_ctrl_write,
  input  logic             avs_ctrl_read,
  output logic             avs_ctrl_waitrequest,
  output logic [WIDTH-1:0] coe_angle,
  output logic             coe_angle_valid,
  output logic             coe_pwm_en,
  output logic             ins_irq
);

  localparam int unsigned DiffW = WIDTH + 1;
  localparam logic [WIDTH-1:0] MinDef    = WIDTH'(MIN_DEF);
  localparam logic [WIDTH-1:0] MaxDef    = WIDTH'(MAX_DEF);
  localparam logic [WIDTH-1:0] CenterVal = WIDTH'(CENTER);

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                             input logic [WIDTH-1:0] lo,
                                             input logic [WIDTH-1:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  logic [2:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [7:0]       step_q, step_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] current_q, current_d;
  logic [0:0]       state_q, state_d;
  logic             done_q, done_d, done_set, done_clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             valid_q, valid_d;
  logic             wd_trip;

  logic             tick, tick_clr;
  logic [31:0]      be_mask, reg_word, status_word, wr_word;
  logic [WIDTH-1:0] tgt_c, cur_c, lim_min, lim_max;
  logic [DiffW-1:0] diff;

`ifdef STEERING_RAMP_WATCHDOG_EN
  localparam int unsigned WdW = (WD_TICKS > 1) ? $clog2(WD_TICKS) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'((WD_TICKS > 0) ? WD_TICKS - 1 : 0);

  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
  logic           wd_trip_q, wd_trip_d, wd_set, wd_clr;

  assign wd_trip = wd_trip_q;
`else
  localparam int unsigned unused_wd_ticks = WD_TICKS;

  assign wd_trip = 1'b0;
`endif

  assign tick_clr = !ctrl_q[CtrlEnBit];

  steering_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_i  (csi_MCLK_clk),
    .rst_i  (rsi_MRST_reset),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // Register readback, also the base value that byteenable-masked writes merge into.
  always_comb begin
    status_word                = '0;
    status_word[StatBusyBit]   = (state_q == StRamp);
    status_word[StatDoneBit]   = done_q;
    status_word[StatWdTripBit] = wd_trip;
    status_word[31:16]         = 16'(current_q);
    case (avs_ctrl_address)
      AddrId:      reg_word = SteeringId;
      AddrCtrl:    reg_word = 32'(ctrl_q);
      AddrTarget:  reg_word = 32'(target_q);
      AddrStep:    reg_word = 32'(step_q);
      AddrLimits:  reg_word = {16'(max_q), 16'(min_q)};
      AddrStatus:  reg_word = status_word;
      AddrCurrent: reg_word = 32'(current_q);
      default:     reg_word = '0;
    endcase
  end

  assign be_mask = {{8{avs_ctrl_byteenable[3]}}, {8{avs_ctrl_byteenable[2]}},
                    {8{avs_ctrl_byteenable[1]}}, {8{avs_ctrl_byteenable[0]}}};
  assign wr_word = (reg_word & ~be_mask) | (avs_ctrl_writedata & be_mask);

  always_comb begin
    ctrl_d    = ctrl_q;
    target_d  = target_q;
    step_d    = step_q;
    min_d     = min_q;
    max_d     = max_q;
    current_d = current_q;
    state_d   = state_q;
    done_set  = 1'b0;
    done_clr  = 1'b0;
    lim_min   = WIDTH'(wr_word[15:0]);
    lim_max   = WIDTH'(wr_word[31:16]);
    tgt_c     = clamp(target_q, min_q, max_q);
    cur_c     = clamp(current_q, min_q, max_q);
    diff      = (tgt_c >= cur_c) ? ({1'b0, tgt_c} - {1'b0, cur_c})
                                 : ({1'b0, cur_c} - {1'b0, tgt_c});
`ifdef STEERING_RAMP_WATCHDOG_EN
    wd_cnt_d  = wd_cnt_q;
    wd_set    = 1'b0;
    wd_clr    = 1'b0;
`endif

    if (tick) begin
      target_d  = tgt_c;
      current_d = cur_c;
      if (state_q == StIdle) begin
        if (cur_c != tgt_c) state_d = StRamp;
      end else if (step_q == '0 || diff <= DiffW'(step_q)) begin
        current_d = tgt_c;
        done_set  = 1'b1;
        state_d   = StIdle;
      end else if (tgt_c > cur_c) begin
        current_d = cur_c + WIDTH'(step_q);
      end else begin
        current_d = cur_c - WIDTH'(step_q);
      end
    end

`ifdef STEERING_RAMP_WATCHDOG_EN
    if (tick && ctrl_q[CtrlWdEnBit] && ctrl_q[CtrlEnBit]) begin
      if (wd_cnt_q == WdLast) begin
        wd_cnt_d = '0;
        wd_set   = 1'b1;
        target_d = clamp(CenterVal, min_q, max_q);
        state_d  = StRamp;
      end else begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end
`endif

    if (!ctrl_q[CtrlEnBit]) state_d = StIdle;

    // Bus writes come last so a TARGET write overrides any tick-time target update.
    if (avs_ctrl_write) begin
      case (avs_ctrl_address)
        AddrCtrl: begin
          ctrl_d = wr_word[2:0];
`ifndef STEERING_RAMP_WATCHDOG_EN
          ctrl_d[CtrlWdEnBit] = 1'b0;
`endif
        end
        AddrTarget: begin
          target_d = clamp(WIDTH'(wr_word), min_q, max_q);
`ifdef STEERING_RAMP_WATCHDOG_EN
          wd_cnt_d = '0;
`endif
          if (ctrl_q[CtrlEnBit]) state_d = StRamp;
        end
        AddrStep: step_d = wr_word[7:0];
        AddrLimits: begin
          if (lim_min <= lim_max) begin
            min_d = lim_min;
            max_d = lim_max;
          end
        end
        AddrStatus: begin
          if (avs_ctrl_byteenable[0]) begin
            done_clr = avs_ctrl_writedata[StatDoneBit];
`ifdef STEERING_RAMP_WATCHDOG_EN
            wd_clr   = avs_ctrl_writedata[StatWdTripBit];
`endif
          end
        end
        default: ;
      endcase
    end

    done_d     = done_set | (done_q & ~done_clr);
`ifdef STEERING_RAMP_WATCHDOG_EN
    wd_trip_d  = wd_set | (wd_trip_q & ~wd_clr);
`endif
    valid_d    = (current_d != current_q);
    readdata_d = avs_ctrl_read ? reg_word : readdata_q;
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      ctrl_q     <= '0;
      target_q   <= CenterVal;
      step_q     <= 8'd1;
      min_q      <= MinDef;
      max_q      <= MaxDef;
      current_q  <= CenterVal;
      state_q    <= StIdle;
      done_q     <= 1'b0;
      readdata_q <= '0;
      valid_q    <= 1'b0;
`ifdef STEERING_RAMP_WATCHDOG_EN
      wd_cnt_q   <= '0;
      wd_trip_q  <= 1'b0;
`endif
    end else begin
      ctrl_q     <= ctrl_d;
      target_q   <= target_d;
      step_q     <= step_d;
      min_q      <= min_d;
      max_q      <= max_d;
      current_q  <= current_d;
      state_q    <= state_d;
      done_q     <= done_d;
      readdata_q <= readdata_d;
      valid_q    <= valid_d;
`ifdef STEERING_RAMP_WATCHDOG_EN
      wd_cnt_q   <= wd_cnt_d;
      wd_trip_q  <= wd_trip_d;
`endif
    end
  end

  assign avs_ctrl_readdata    = readdata_q;
  assign avs_ctrl_waitrequest = 1'b0;
  assign coe_angle            = current_q;
  assign coe_angle_valid      = valid_q;
  assign coe_pwm_en           = ctrl_q[CtrlEnBit];
  assign ins_irq              = ctrl_q[CtrlIrqEnBit] & (done_q | wd_trip);

endmodule

// File: tb/tb_steering_ramp_ctrl.sv
// Directed bench for steering_ramp_ctrl with TICK_DIV=10 and WD_TICKS=3.
module tb_steering_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  byteenable;
  logic [2:0]  address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [15:0] angle;
  logic        angle_valid;
  logic        pwm_en;
  logic        irq;

  int          ncmp = 0;
  int          nerr = 0;
  int          vcount = 0;
  int          base;
  int          cyc;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  steering_ramp_ctrl #(
    .WIDTH    (16),
    .TICK_DIV (10),
    .MIN_DEF  (100),
    .MAX_DEF  (200),
    .CENTER   (150),
    .WD_TICKS (3)
  ) dut (
    .csi_MCLK_clk         (clk),
    .rsi_MRST_reset       (rst),
    .avs_ctrl_writedata   (writedata),
    .avs_ctrl_readdata    (readdata),
    .avs_ctrl_byteenable  (byteenable),
    .avs_ctrl_address     (address),
    .avs_ctrl_write       (write),
    .avs_ctrl_read        (read),
    .avs_ctrl_waitrequest (waitrequest),
    .coe_angle            (angle),
    .coe_angle_valid      (angle_valid),
    .coe_pwm_en           (pwm_en),
    .ins_irq              (irq)
  );

  always @(posedge clk) begin
    #1;
    if (angle_valid === 1'b1) vcount++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    @(negedge clk);
    write      = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    read    = 1'b1;
    @(negedge clk);
    read    = 1'b0;
    d       = readdata;
  endtask

  task automatic wait_pulses(input int n, input string tag);
    int k = 0;
    while (vcount < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(vcount >= n), 32'd1);
  endtask

  initial begin
    rst = 1'b1; writedata = '0; byteenable = 4'hF; address = '0; write = 1'b0; read = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_angle", 32'(angle), 32'd150);
    chk("rst_valid", 32'(angle_valid), 32'd0);
    chk("rst_pwm_en", 32'(pwm_en), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_waitreq", 32'(waitrequest), 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    rd(3'd0, rdata); chk("rd_id", rdata, 32'hEA680013);
    rd(3'd6, rdata); chk("rd_current", rdata, 32'd150);
    rd(3'd2, rdata); chk("rd_target_rst", rdata, 32'd150);
    rd(3'd3, rdata); chk("rd_step_rst", rdata, 32'd1);
    rd(3'd4, rdata); chk("rd_limits_rst", rdata, 32'h00C8_0064);
    rd(3'd5, rdata); chk("rd_status_rst", rdata, 32'h0096_0000);
    rd(3'd1, rdata); chk("rd_ctrl_rst", rdata, 32'd0);
    rd(3'd7, rdata); chk("rd_addr7", rdata, 32'd0);

    // Ramp 150 -> 180 in steps of 10
    wr(3'd1, 32'd1, 4'hF);
    chk("pwm_en_on", 32'(pwm_en), 32'd1);
    wr(3'd3, 32'd10, 4'hF);
    wr(3'd2, 32'd180, 4'hF);
    wait_pulses(1, "wait_160");
    chk("ramp_160", 32'(angle), 32'd160);
    rd(3'd5, rdata); chk("status_busy", rdata, 32'h00A0_0001);
    wait_pulses(2, "wait_170");
    chk("ramp_170", 32'(angle), 32'd170);
    wait_pulses(3, "wait_180");
    chk("ramp_180", 32'(angle), 32'd180);
    rd(3'd5, rdata); chk("status_done", rdata, 32'h00B4_0002);

    // Target clamp, rejected limits, byteenable
    wr(3'd2, 32'd250, 4'hF);
    rd(3'd2, rdata); chk("target_clamped", rdata, 32'd200);
    wr(3'd4, {16'd120, 16'd190}, 4'hF);
    rd(3'd4, rdata); chk("limits_rejected", rdata, 32'h00C8_0064);
    wr(3'd3, 32'h0000_0520, 4'b0010);
    rd(3'd3, rdata); chk("step_be_masked", rdata, 32'd10);
    wait_pulses(4, "wait_190");
    chk("ramp_190", 32'(angle), 32'd190);
    wait_pulses(5, "wait_200");
    chk("ramp_200", 32'(angle), 32'd200);

    // Interrupt and W1C, STEP=0 jump
    wr(3'd1, 32'd3, 4'hF);
    chk("irq_done_pending", 32'(irq), 32'd1);
    wr(3'd5, 32'd2, 4'b0010);
    chk("irq_w1c_wrong_lane", 32'(irq), 32'd1);
    wr(3'd5, 32'd2, 4'b0001);
    chk("irq_w1c_clear", 32'(irq), 32'd0);
    wr(3'd3, 32'd0, 4'hF);
    wr(3'd2, 32'd110, 4'hF);
    wait_pulses(6, "wait_110");
    chk("jump_110", 32'(angle), 32'd110);
    chk("irq_after_jump", 32'(irq), 32'd1);
    repeat (25) @(negedge clk);
    chk("single_pulse", 32'(vcount), 32'd6);
    wr(3'd5, 32'd2, 4'hF);
    chk("irq_cleared", 32'(irq), 32'd0);

    // Disable mid-ramp, then re-enable and time the restart
    wr(3'd3, 32'd10, 4'hF);
    wr(3'd2, 32'd180, 4'hF);
    wait_pulses(11, "wait_mid_160");
    chk("mid_160", 32'(angle), 32'd160);
    wr(3'd1, 32'd0, 4'hF);
    chk("pwm_en_off", 32'(pwm_en), 32'd0);
    repeat (30) @(negedge clk);
    chk("hold_160", 32'(angle), 32'd160);
    chk("hold_no_pulse", 32'(vcount), 32'd11);
    rd(3'd5, rdata); chk("status_idle_off", rdata, 32'h00A0_0000);
    wr(3'd1, 32'd1, 4'hF);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (angle_valid === 1'b1) begin
        cyc = i;
        break;
      end
    end
    chk("restart_cycles", 32'(cyc), 32'd20);
    chk("restart_170", 32'(angle), 32'd170);

    // Reset mid-ramp
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_angle_async", 32'(angle), 32'd150);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_pwm_en", 32'(pwm_en), 32'd0);
    chk("rst2_irq", 32'(irq), 32'd0);
    rd(3'd2, rdata); chk("rst2_target", rdata, 32'd150);
    rd(3'd3, rdata); chk("rst2_step", rdata, 32'd1);
    rd(3'd4, rdata); chk("rst2_limits", rdata, 32'h00C8_0064);
    rd(3'd1, rdata); chk("rst2_ctrl", rdata, 32'd0);
    rd(3'd5, rdata); chk("rst2_status", rdata, 32'h0096_0000);

    // CTRL wd_en bit presence
    wr(3'd1, 32'd7, 4'hF);
    rd(3'd1, rdata);
`ifdef STEERING_RAMP_WATCHDOG_EN
    chk("ctrl_wd_bit", rdata, 32'd7);
`else
    chk("ctrl_wd_bit", rdata, 32'd3);
`endif
    wr(3'd1, 32'd0, 4'hF);

`ifdef STEERING_RAMP_WATCHDOG_EN
    // Watchdog trip re-centres: ramp to 180, then three silent ticks
    base = vcount;
    wr(3'd1, 32'd1, 4'hF);
    wr(3'd3, 32'd10, 4'hF);
    wr(3'd2, 32'd180, 4'hF);
    wait_pulses(base + 3, "wd_wait_180");
    chk("wd_at_180", 32'(angle), 32'd180);
    wr(3'd1, 32'd5, 4'hF);
    wait_pulses(base + 4, "wd_wait_170");
    chk("wd_ramp_170", 32'(angle), 32'd170);
    rd(3'd2, rdata); chk("wd_target", rdata, 32'd150);
    rd(3'd5, rdata); chk("wd_status", rdata, 32'h00AA_0007);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
